// File: rtl/v_duty_sched.sv
// rtl/v_duty_sched.sv - per-block backlight duty scheduler driven by VSYNC/DE timing
module v_duty_sched #(
    parameter int LPB  = 270,
    parameter int NBLK = 4
) (
    input  logic       iODCK,
    input  logic       iRST,
    input  logic       iVSYNC,
    input  logic       iDE,
    input  logic [1:0] iDutySW,
    input  logic       iDutyWr,
    input  logic [1:0] iDutyAddr,
    input  logic [8:0] iDutyData,
    output logic       oV_Duty,
    output logic [1:0] oBlk,
    output logic       oBlkStart,
    output logic       oFrameDone,
    output logic       oFrameErr,
    output logic       oBusy
);
    localparam logic [8:0] LPB_W    = 9'(LPB);
    localparam logic [8:0] LPB_M1   = 9'(LPB - 1);
    localparam logic [1:0] LAST_BLK = 2'(NBLK - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DE, S_ACTIVE, S_BLANK} state_t;

    state_t     state_q, state_d;
    logic [8:0] lc_q, lc_d;
    logic [1:0] bc_q, bc_d;
    logic       vduty_q, vduty_d;
    logic       blk_start_q, blk_start_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_err_q, frame_err_d;
    logic       vs_q, vs_prev_q, de_q, de_prev_q;
    logic [8:0] sh_q  [4];
    logic [8:0] act_q [4];
    logic [1:0] mode_q;
    logic [8:0] eff_duty;
    logic       vs_rise, de_fall;

    assign vs_rise = vs_q & ~vs_prev_q;
    assign de_fall = de_prev_q & ~de_q;

    // VSYNC history resets high so a sync already asserted at release is not seen as a rise
    always_ff @(posedge iODCK or posedge iRST) begin
        if (iRST) begin
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
        end else begin
            vs_q      <= iVSYNC;
            vs_prev_q <= vs_q;
            de_q      <= iDE;
            de_prev_q <= de_q;
        end
    end

    // a shadow write coinciding with VS_rise lands in SH after ACT has sampled the old value
    always_ff @(posedge iODCK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < 4; i++) begin
                sh_q[i]  <= 9'd0;
                act_q[i] <= 9'd0;
            end
            mode_q <= 2'b00;
        end else begin
            if (iDutyWr) begin
                sh_q[iDutyAddr] <= iDutyData;
            end
            if (vs_rise) begin
                for (int i = 0; i < 4; i++) begin
                    act_q[i] <= sh_q[i];
                end
                mode_q <= iDutySW;
            end
        end
    end

    always_comb begin
        eff_duty = act_q[bc_q];
        case (mode_q)
            2'b00:   eff_duty = LPB_W;
            2'b10:   eff_duty = 9'd0;
            default: eff_duty = act_q[bc_q];
        endcase
    end

    always_ff @(posedge iODCK or posedge iRST) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            lc_q         <= 9'd0;
            bc_q         <= 2'd0;
            vduty_q      <= 1'b0;
            blk_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lc_q         <= lc_d;
            bc_q         <= bc_d;
            vduty_q      <= vduty_d;
            blk_start_q  <= blk_start_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lc_d         = lc_q;
        bc_d         = bc_q;
        blk_start_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        vduty_d      = (state_q == S_ACTIVE) && !vs_rise && (lc_q < eff_duty);
        case (state_q)
            S_IDLE: begin
                if (vs_rise) begin
                    state_d = S_WAIT_DE;
                    lc_d    = 9'd0;
                    bc_d    = 2'd0;
                end
            end
            S_WAIT_DE: begin
                if (vs_rise) begin
                    frame_err_d = 1'b1;
                    lc_d        = 9'd0;
                    bc_d        = 2'd0;
                end else if (de_q) begin
                    state_d     = S_ACTIVE;
                    blk_start_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = S_WAIT_DE;
                    lc_d        = 9'd0;
                    bc_d        = 2'd0;
                end else if (de_fall) begin
                    if (lc_q == LPB_M1) begin
                        lc_d = 9'd0;
                        bc_d = bc_q + 2'd1;
                        if (bc_q == LAST_BLK) begin
                            state_d      = S_BLANK;
                            frame_done_d = 1'b1;
                        end else begin
                            blk_start_d = 1'b1;
                        end
                    end else begin
                        lc_d = lc_q + 9'd1;
                    end
                end
            end
            S_BLANK: begin
                if (vs_rise) begin
                    state_d = S_WAIT_DE;
                    lc_d    = 9'd0;
                    bc_d    = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy      = (state_q != S_IDLE);
        oBlk       = bc_q;
        oV_Duty    = vduty_q;
        oBlkStart  = blk_start_q;
        oFrameDone = frame_done_q;
        oFrameErr  = frame_err_q;
    end
endmodule

// File: tb/tb_v_duty_sched.sv
// tb/tb_v_duty_sched.sv - scoreboard bench for v_duty_sched with a line-level reference model
module tb_v_duty_sched;
    localparam int LPB = 4;
    localparam int NL  = 4 * LPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0, de = 1'b0, wr = 1'b0;
    logic [1:0] sw = 2'd0, addr = 2'd0;
    logic [8:0] data = 9'd0;
    logic       v_duty, blk_start, frame_done, frame_err, busy;
    logic [1:0] blk;

    always #5 clk = ~clk;

    v_duty_sched #(.LPB(LPB), .NBLK(4)) dut (
        .iODCK(clk), .iRST(rst), .iVSYNC(vs), .iDE(de),
        .iDutySW(sw), .iDutyWr(wr), .iDutyAddr(addr), .iDutyData(data),
        .oV_Duty(v_duty), .oBlk(blk), .oBlkStart(blk_start),
        .oFrameDone(frame_done), .oFrameErr(frame_err), .oBusy(busy)
    );

    int total = 0;
    int bad = 0;
    int line_q[$];
    int ev_kind_q[$];
    int ev_blk_q[$];

    int m_sh[4];
    int m_act[4];
    int m_mode;
    bit m_valid;
    int m_lines;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int eff(input int b);
        if (m_mode == 0) return LPB;
        if (m_mode == 2) return 0;
        return m_act[b];
    endfunction

    function automatic int exp_line();
        if (m_valid && m_lines < NL)
            return ((m_lines % LPB) < eff(m_lines / LPB)) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_mode  = 0;
        m_valid = 0;
        m_lines = 0;
    endtask

    task automatic push_ev(input int kind, input int b);
        ev_kind_q.push_back(kind);
        ev_blk_q.push_back(b);
    endtask

    task automatic wr_sh(input int a, input int d);
        @(negedge clk);
        wr = 1'b1; addr = 2'(a); data = 9'(d);
        @(negedge clk);
        wr = 1'b0;
        m_sh[a] = d;
    endtask

    task automatic vs_pulse(input int mode, input bit same_wr, input int a, input int d);
        @(negedge clk);
        sw = 2'(mode);
        if (m_valid && m_lines < NL) push_ev(3, 0);
        vs = 1'b1;
        @(negedge clk);
        if (same_wr) begin
            wr = 1'b1; addr = 2'(a); data = 9'(d);
        end
        @(negedge clk);
        wr = 1'b0;
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_mode  = mode;
        m_valid = 1;
        m_lines = 0;
        if (same_wr) m_sh[a] = d;
        check("vduty_after_vs", int'(v_duty), 0);
        check("busy_after_vs", int'(busy), 1);
        check("blk_after_vs", int'(blk), 0);
        @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line();
        line_q.push_back(exp_line());
        if (m_valid && m_lines == 0) push_ev(1, 0);
        @(negedge clk);
        de = 1'b1;
        repeat (5) @(negedge clk);
        de = 1'b0;
        if (m_valid && m_lines < NL) begin
            m_lines++;
            if (m_lines == NL) push_ev(2, 0);
            else if (m_lines % LPB == 0) push_ev(1, m_lines / LPB);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) send_line();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_vduty"}, int'(v_duty), 0);
        check({tag, "_blkstart"}, int'(blk_start), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_blk"}, int'(blk), 0);
    endtask

    // line monitor: compares oV_Duty well inside each DE run, independent of the driver
    int de_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (de) de_cnt++;
        else de_cnt = 0;
        if (de_cnt == 5) begin
            if (line_q.size() == 0) check("line_unexpected", 1, 0);
            else check("line_vduty", int'(v_duty), line_q.pop_front());
        end
    end

    task automatic ev_check(input int kind);
        if (ev_kind_q.size() == 0) begin
            check("event_unexpected_kind", kind, 0);
        end else begin
            check("event_kind", kind, ev_kind_q.pop_front());
            check("event_blk", int'(blk), ev_blk_q.pop_front());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (blk_start) ev_check(1);
        if (frame_done) ev_check(2);
        if (frame_err) ev_check(3);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wr_sh(0, 2); wr_sh(1, 0); wr_sh(2, 4); wr_sh(3, 1);
        vs_pulse(1, 0, 0, 0);
        lines(NL);

        vs_pulse(0, 0, 0, 0);
        lines(NL);
        vs_pulse(2, 0, 0, 0);
        lines(NL);

        vs_pulse(1, 1, 1, 3);
        lines(NL);
        vs_pulse(1, 0, 0, 0);
        lines(NL);

        vs_pulse(1, 0, 0, 0);
        lines(6);
        vs_pulse(1, 0, 0, 0);
        lines(NL);

        vs_pulse(1, 0, 0, 0);
        lines(20);

        for (int f = 0; f < 6; f++) begin
            int nw;
            nw = int'($urandom_range(3, 0));
            for (int k = 0; k < nw; k++)
                wr_sh(int'($urandom_range(3, 0)), int'($urandom_range(6, 0)));
            vs_pulse(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                     int'($urandom_range(3, 0)), int'($urandom_range(6, 0)));
            lines(int'($urandom_range(20, 0)));
        end

        wr_sh(2, 4);
        vs_pulse(1, 0, 0, 0);
        lines(10);
        check("vduty_before_rst", int'(v_duty), exp_line());
        #2 rst = 1'b1;
        #1 check_quiet("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lines(2);
        check_quiet("post_rst_idle");
        wr_sh(0, 1); wr_sh(1, 3); wr_sh(2, 0); wr_sh(3, 5);
        vs_pulse(1, 0, 0, 0);
        lines(NL);

        repeat (10) @(negedge clk);
        check("line_queue_drained", line_q.size(), 0);
        check("event_queue_drained", ev_kind_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/v_duty_sched.md
V_DUTY_SCHED -- requirements
Module: v_duty_sched

Interface
REQ-001 SHALL have parameter LPB, default 270, meaning active lines per vertical block (1..511).
REQ-002 SHALL have parameter NBLK, fixed at 4, meaning the number of vertical blocks per frame.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: iODCK input 1, pixel clock (all logic on posedge); iRST input 1, asynchronous active-high reset.
REQ-004 SHALL have these ports: iVSYNC input 1, frame sync (active-high level); iDE input 1, data enable (one high run per line).
REQ-005 SHALL have these ports: iDutySW input 2, duty mode; iDutyWr input 1, shadow write strobe; iDutyAddr input 2, block index; iDutyData input 9, duty in lines.
REQ-006 SHALL have these outputs: oV_Duty output 1, backlight enable for the current block; oBlk output 2, current block index.
REQ-007 SHALL have these outputs: oBlkStart output 1, one-cycle pulse at block entry; oFrameDone output 1, one-cycle pulse; oFrameErr output 1, one-cycle pulse; oBusy output 1, high outside IDLE.

Function
REQ-008 SHALL register iVSYNC and iDE once. VS_rise and DE_fall are detected from the registered copies, so event latency is 1 cycle from the pin.
REQ-009 SHALL hold four 9-bit shadow duty registers, SH[0..3]. iDutyWr=1 writes iDutyData into SH[iDutyAddr] at that clock edge.
REQ-010 SHALL, on VS_rise, copy SH[0..3] to active registers ACT[0..3] and latch iDutySW into MODE. A shadow write in the same cycle as VS_rise is excluded and takes effect at the next frame.
REQ-011 SHALL resolve the effective duty per block from MODE: 2'b00 gives LPB (MAX, full on); 2'b01 and 2'b11 give ACT[b]; 2'b10 gives 0 (off).
REQ-012 SHALL implement FSM state IDLE: wait for VS_rise, then go to WAIT_DE with oBlk=0, line counter LC=0, block counter BC=0.
REQ-013 SHALL implement FSM state WAIT_DE: on the first registered iDE high, go to ACTIVE and pulse oBlkStart for block 0.
REQ-014 SHALL implement FSM state ACTIVE with these rules:
- Each DE_fall increments LC.
- When LC reaches LPB-1 and DE_fall occurs, LC wraps to 0 and BC increments.
- On BC advance to 1..3, oBlkStart pulses in the same cycle as the wrap.
- On DE_fall of the last line of block 3, go to BLANK and pulse oFrameDone.
REQ-015 SHALL implement FSM state BLANK: ignore iDE and any extra lines; on VS_rise, perform REQ-010 and go to WAIT_DE.
REQ-016 SHALL drive oV_Duty = 1 only in ACTIVE and only while LC < effective duty of block BC. The value is registered and changes in the cycle after the LC/BC update.
REQ-017 SHALL treat duty boundaries as follows: duty 0 keeps oV_Duty low for the whole block; duty >= LPB keeps it high for the whole block, with no clamp error.
REQ-018 SHALL treat VS_rise in WAIT_DE or ACTIVE as a short frame:
- pulse oFrameErr;
- suppress oFrameDone;
- perform REQ-010;
- restart at WAIT_DE with LC=BC=0 and oV_Duty=0 in the next cycle.
REQ-019 SHALL keep LC at 9 bits and BC at 2 bits, with no arithmetic overflow beyond the LPB wrap. oBlk SHALL equal BC.

Reset
REQ-020 SHALL, while iRST=1 (asynchronously), force:
- state IDLE;
- SH, ACT and MODE to 0;
- LC and BC to 0;
- oV_Duty, oBlkStart, oFrameDone, oFrameErr and oBusy to 0.
REQ-021 SHALL apply reset asserted mid-frame immediately. After release, no output pulses until the next VS_rise.

Verification
REQ-022 SHALL be verified with this scenario: LPB=4, write SH={2,0,4,1}, MODE 01, VS pulse then 16 DE lines -> oV_Duty high on lines 0-1, none, 8-11, 12; oBlkStart x4; oFrameDone once.
REQ-023 SHALL be verified with this scenario: MODE 00 then 10 in consecutive frames -> all 16 lines high, then all 16 lines low.
REQ-024 SHALL be verified with this scenario: iDutyWr in the same cycle as VS_rise -> the new value is absent in that frame and present in the next.
REQ-025 SHALL be verified with this scenario: VS_rise after 6 of 16 lines -> oFrameErr pulse, no oFrameDone, next frame starts at oBlk=0 with correct duties.
REQ-026 SHALL be verified with this scenario: 20 DE lines in a frame -> lines 17-20 are ignored, oV_Duty stays 0 and oFrameDone pulses only once.
REQ-027 SHALL be verified with this scenario: iRST pulse mid-block 2 -> all outputs 0 immediately, oBusy=0, and normal operation resumes at the next VSYNC.
